cdb_arbiter: RTL and testbench

- Round-robin arbiter that shares the single Common Data Bus (CDB) among the Tomasulo functional-unit reservation stations: ALU, MUL, DIV and load buffer.
- Grants at most one requester per cycle and drives the registered CDB broadcast (tag, value, ICC flags) to all reservation stations and the register file.
- Acknowledges the winner so its station can free the entry.

---
 rtl/cdb_arbiter.sv | 130 +++++++++++++
 tb/tb_cdb_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter (ALU, MUL, DIV, LOAD): one registered broadcast per cycle, 1-cycle request-to-broadcast latency.
// Requests are held until acknowledged; the station just granted is masked for one cycle so a stale result is never rebroadcast.
module cdb_arbiter #(
    parameter int                 N_REQ       = 4,
    parameter int                 TAG_W       = 5,
    parameter int                 VAL_W       = 32,
    parameter logic [TAG_W-1:0]   INVALID_TAG = {TAG_W{1'b1}}
) (
    input  logic                   clk,
    input  logic                   in_rst_n,
    input  logic [N_REQ-1:0]       in_req,
    input  logic [N_REQ*TAG_W-1:0] in_tag,
    input  logic [N_REQ*VAL_W-1:0] in_val,
    input  logic [N_REQ*4-1:0]     in_icc,
    input  logic [N_REQ-1:0]       in_icc_we,
    input  logic                   in_flush,
    output logic [N_REQ-1:0]       out_ack,
    output logic                   out_CDB_broadcast,
    output logic [TAG_W-1:0]       out_CDB_tag,
    output logic [VAL_W-1:0]       out_CDB_val,
    output logic [3:0]             out_ICC_flags,
    output logic                   out_tag_err
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] ptr_q,   ptr_d;
    logic [N_REQ-1:0] mask_q,  mask_d;
    logic [N_REQ-1:0] ack_q,   ack_d;
    logic             bcast_q, bcast_d;
    logic [TAG_W-1:0] tag_q,   tag_d;
    logic [VAL_W-1:0] val_q,   val_d;
    logic [3:0]       icc_q,   icc_d;
    logic             err_q,   err_d;

    logic [TAG_W-1:0] tag_arr [N_REQ];
    logic [VAL_W-1:0] val_arr [N_REQ];
    logic [3:0]       icc_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign tag_arr[i] = in_tag[i*TAG_W +: TAG_W];
        assign val_arr[i] = in_val[i*VAL_W +: VAL_W];
        assign icc_arr[i] = in_icc[i*4 +: 4];
    end

    logic [N_REQ-1:0] req_eff;
    logic             win_vld;
    logic [PTR_W-1:0] win_idx;
    logic             grant;
    int               scan_sum;
    logic [PTR_W-1:0] scan_idx;

    // Circular priority scan starting at the pointer; first eligible request wins.
    always_comb begin
        req_eff  = in_req & ~mask_q;
        win_vld  = 1'b0;
        win_idx  = ptr_q;
        scan_sum = 0;
        scan_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_sum = int'(ptr_q) + k;
            if (scan_sum >= N_REQ) begin
                scan_sum = scan_sum - N_REQ;
            end
            scan_idx = PTR_W'(scan_sum);
            if (!win_vld && req_eff[scan_idx]) begin
                win_vld = 1'b1;
                win_idx = scan_idx;
            end
        end
        grant = win_vld & ~in_flush;
    end

    always_comb begin
        ptr_d   = ptr_q;
        mask_d  = '0;
        ack_d   = '0;
        bcast_d = 1'b0;
        tag_d   = tag_q;
        val_d   = val_q;
        icc_d   = icc_q;
        err_d   = err_q;
        if (grant) begin
            ack_d[win_idx]  = 1'b1;
            mask_d[win_idx] = 1'b1;
            ptr_d = (win_idx == PTR_W'(N_REQ-1)) ? '0 : win_idx + 1'b1;
            // An INVALID_TAG winner is consumed (acked) but never reaches the bus.
            if (tag_arr[win_idx] == INVALID_TAG) begin
                err_d = 1'b1;
            end else begin
                bcast_d = 1'b1;
                tag_d   = tag_arr[win_idx];
                val_d   = val_arr[win_idx];
                if (in_icc_we[win_idx]) begin
                    icc_d = icc_arr[win_idx];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            ptr_q   <= '0;
            mask_q  <= '0;
            ack_q   <= '0;
            bcast_q <= 1'b0;
            tag_q   <= '0;
            val_q   <= '0;
            icc_q   <= 4'b0000;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            mask_q  <= mask_d;
            ack_q   <= ack_d;
            bcast_q <= bcast_d;
            tag_q   <= tag_d;
            val_q   <= val_d;
            icc_q   <= icc_d;
            err_q   <= err_d;
        end
    end

    assign out_ack           = ack_q;
    assign out_CDB_broadcast = bcast_q;
    assign out_CDB_tag       = tag_q;
    assign out_CDB_val       = val_q;
    assign out_ICC_flags     = icc_q;
    assign out_tag_err       = err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboarded random + directed bench for cdb_arbiter.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int TW = 5;
    localparam int VW = 32;

    logic            clk = 1'b0;
    logic            in_rst_n;
    logic [N-1:0]    in_req;
    logic [N*TW-1:0] in_tag;
    logic [N*VW-1:0] in_val;
    logic [N*4-1:0]  in_icc;
    logic [N-1:0]    in_icc_we;
    logic            in_flush;
    logic [N-1:0]    out_ack;
    logic            out_CDB_broadcast;
    logic [TW-1:0]   out_CDB_tag;
    logic [VW-1:0]   out_CDB_val;
    logic [3:0]      out_ICC_flags;
    logic            out_tag_err;

    cdb_arbiter dut (
        .clk               (clk),
        .in_rst_n          (in_rst_n),
        .in_req            (in_req),
        .in_tag            (in_tag),
        .in_val            (in_val),
        .in_icc            (in_icc),
        .in_icc_we         (in_icc_we),
        .in_flush          (in_flush),
        .out_ack           (out_ack),
        .out_CDB_broadcast (out_CDB_broadcast),
        .out_CDB_tag       (out_CDB_tag),
        .out_CDB_val       (out_CDB_val),
        .out_ICC_flags     (out_ICC_flags),
        .out_tag_err       (out_tag_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  ack;
        logic          bc;
        logic [TW-1:0] tag;
        logic [VW-1:0] val;
        logic [3:0]    icc;
        logic          err;
    } exp_t;

    // station-side stimulus state
    logic          st_req [N];
    logic [TW-1:0] st_tag [N];
    logic [VW-1:0] st_val [N];
    logic [3:0]    st_icc [N];
    logic          st_we  [N];
    logic          flush_s;

    // reference model state
    int            m_ptr;
    int            m_last;
    logic [3:0]    m_icc;
    logic          m_err;
    logic [TW-1:0] m_tag;
    logic [VW-1:0] m_val;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 0;

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            in_req[i]             = st_req[i];
            in_tag[i*TW +: TW]    = st_tag[i];
            in_val[i*VW +: VW]    = st_val[i];
            in_icc[i*4 +: 4]      = st_icc[i];
            in_icc_we[i]          = st_we[i];
        end
        in_flush = flush_s;
    endtask

    task automatic clear_stations();
        for (int i = 0; i < N; i++) begin
            st_req[i] = 1'b0;
            st_tag[i] = '0;
            st_val[i] = '0;
            st_icc[i] = '0;
            st_we[i]  = 1'b0;
        end
        flush_s = 1'b0;
    endtask

    task automatic set_station(int i, logic [TW-1:0] t, logic [VW-1:0] v, logic [3:0] c, logic we);
        st_req[i] = 1'b1;
        st_tag[i] = t;
        st_val[i] = v;
        st_icc[i] = c;
        st_we[i]  = we;
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_last = -1;
        m_icc  = 4'b0000;
        m_err  = 1'b0;
        m_tag  = '0;
        m_val  = '0;
        q.delete();
    endtask

    // Drive this cycle's inputs, predict the next-edge outputs, advance to the next negedge.
    task automatic step();
        exp_t e;
        int   w;
        apply();
        w = -1;
        if (!flush_s) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (w < 0 && st_req[idx] && idx != m_last) w = idx;
            end
        end
        e.ack = '0;
        e.bc  = 1'b0;
        if (w >= 0) begin
            e.ack = 4'(1 << w);
            m_ptr = (w + 1) % N;
            if (st_tag[w] == 5'h1f) begin
                m_err = 1'b1;
            end else begin
                e.bc  = 1'b1;
                m_tag = st_tag[w];
                m_val = st_val[w];
                if (st_we[w]) m_icc = st_icc[w];
            end
        end
        m_last = w;
        e.tag  = m_tag;
        e.val  = m_val;
        e.icc  = m_icc;
        e.err  = m_err;
        q.push_back(e);
        mon_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        mon_en   = 1'b0;
        in_rst_n = 1'b0;
        clear_stations();
        apply();
        model_reset();
        repeat (2) @(negedge clk);
        in_rst_n = 1'b1;
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic new_data(int i);
        logic [TW-1:0] t;
        t = ($urandom % 8 == 0) ? 5'h1f : 5'($urandom % 31);
        set_station(i, t, $urandom, 4'($urandom), 1'($urandom % 2));
    endtask

    // monitor: compares every enabled cycle against the oldest prediction
    initial begin
        exp_t e;
        exp_t a;
        int   cyc;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                cyc++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_underflow cyc %0d: no prediction queued", cyc);
                end else begin
                    e = q.pop_front();
                    a.ack = out_ack;
                    a.bc  = out_CDB_broadcast;
                    a.tag = out_CDB_tag;
                    a.val = out_CDB_val;
                    a.icc = out_ICC_flags;
                    a.err = out_tag_err;
                    if (a !== e) begin
                        errors++;
                        $display("FAIL cdb_out cyc %0d: got ack=%b bc=%b tag=%0d val=%h icc=%b err=%b, expected ack=%b bc=%b tag=%0d val=%h icc=%b err=%b",
                                 cyc, a.ack, a.bc, a.tag, a.val, a.icc, a.err, e.ack, e.bc, e.tag, e.val, e.icc, e.err);
                    end
                end
                checks++;
                if (!$onehot0(out_ack)) begin
                    errors++;
                    $display("FAIL ack_onehot cyc %0d: got %b expected at most one bit", cyc, out_ack);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        do_reset();
        chk("rst_ack",   64'(out_ack), 64'h0);
        chk("rst_bcast", 64'(out_CDB_broadcast), 64'h0);
        chk("rst_tag",   64'(out_CDB_tag), 64'h0);
        chk("rst_val",   64'(out_CDB_val), 64'h0);
        chk("rst_icc",   64'(out_ICC_flags), 64'h0);
        chk("rst_err",   64'(out_tag_err), 64'h0);

        // single MUL request
        set_station(1, 5'd6, 32'h0000_0015, 4'b0000, 1'b1);
        step();
        st_req[1] = 1'b0;
        step();
        step();

        // full contention from a fresh pointer: tags 1,2,3,4,1,...
        do_reset();
        for (int i = 0; i < N; i++) set_station(i, 5'(i + 1), 32'hA000_0000 + i, 4'(i), 1'b0);
        repeat (9) step();
        clear_stations();
        step();

        // ICC selectivity
        set_station(0, 5'd10, 32'h1111, 4'b0100, 1'b1);
        step();
        st_req[0] = 1'b0;
        set_station(1, 5'd11, 32'h2222, 4'b1111, 1'b0);
        step();
        st_req[1] = 1'b0;
        step();
        chk("icc_select", 64'(out_ICC_flags), 64'h4);

        // INVALID_TAG on DIV, then a normal broadcast
        set_station(2, 5'h1f, 32'hDEAD, 4'b1001, 1'b1);
        step();
        st_req[2] = 1'b0;
        set_station(0, 5'd9, 32'h9999, 4'b0001, 1'b0);
        step();
        st_req[0] = 1'b0;
        step();
        chk("tag_err_sticky", 64'(out_tag_err), 64'h1);

        // flush cancels the cycle's arbitration
        set_station(0, 5'd3, 32'h3333, 4'b0010, 1'b1);
        flush_s = 1'b1;
        step();
        flush_s = 1'b0;
        step();
        st_req[0] = 1'b0;
        step();

        // randomized traffic with protocol-following stations
        for (int c = 0; c < 400; c++) begin
            if (m_last >= 0) begin
                if ($urandom % 2 == 0) st_req[m_last] = 1'b0;
                else new_data(m_last);
            end
            for (int i = 0; i < N; i++) begin
                if (!st_req[i] && ($urandom % 10 < 3)) new_data(i);
            end
            flush_s = ($urandom % 16 == 0);
            step();
        end
        clear_stations();
        step();
        step();

        // async reset in the middle of a broadcast cycle
        do_reset();
        set_station(0, 5'd7, 32'h7777, 4'b1010, 1'b1);
        step();
        mon_en = 1'b0;
        chk("pre_rst_bcast", 64'(out_CDB_broadcast), 64'h1);
        #1 in_rst_n = 1'b0;
        #1;
        chk("async_rst_bcast", 64'(out_CDB_broadcast), 64'h0);
        chk("async_rst_ack",   64'(out_ack), 64'h0);
        chk("async_rst_icc",   64'(out_ICC_flags), 64'h0);
        clear_stations();
        apply();
        @(negedge clk);
        @(negedge clk);
        in_rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < N; i++) set_station(i, 5'(i + 1), 32'hB000_0000 + i, 4'b0000, 1'b0);
        step();
        chk("post_rst_first_ack", 64'(out_ack), 64'h1);
        clear_stations();
        step();
        step();
        mon_en = 1'b0;
        chk("scoreboard_drained", 64'(q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
